// File: rtl/lsu_mmio_pipe.sv
// lsu_mmio_pipe: RV32I load/store unit over a byte-lane data RAM and MMIO regs.
// Stores retire in the accept cycle; loads answer one cycle after accept.
module lsu_mmio_pipe #(
   parameter int          DMEM_WORDS = 256,
   parameter logic [31:0] OUT_BASE   = 32'h400,
   parameter int          NUM_OUT    = 11,
   parameter logic [31:0] IN_BASE    = 32'h500,
   parameter int          NUM_IN     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [2:0]            funct3_i,
   input  logic [31:0]           addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  ready_o,
   output logic                  rvalid_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   input  logic [32*NUM_IN-1:0]  io_in_i,
   output logic [32*NUM_OUT-1:0] io_out_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   localparam int          AW     = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
   localparam logic [29:0] DM_LIM = 30'(DMEM_WORDS);
   localparam logic [29:0] OUT_W  = OUT_BASE[31:2];
   localparam logic [29:0] IN_W   = IN_BASE[31:2];

   logic [0:0]           r_state;
   logic [31:0]          r_mem [DMEM_WORDS];
   logic [31:0]          r_out [NUM_OUT];
   logic [32*NUM_IN-1:0] r_sync1;
   logic [32*NUM_IN-1:0] r_sync2;
   logic [31:0]          r_rdata;
   logic                 r_lerr;

   logic [29:0]   w_word;
   logic [AW-1:0] w_midx;
   logic          w_in_dm;
   logic          w_in_out;
   logic          w_in_in;
   logic          w_f3_ok;
   logic          w_misal;
   logic          w_err;
   logic          w_acc;
   logic          w_st;
   logic          w_ld;
   logic          w_wr;
   logic [3:0]    w_be;
   logic [31:0]   w_wlane;
   logic [31:0]   w_rword;
   logic [31:0]   w_shift;
   logic [31:0]   w_lval;

   assign w_word   = addr_i[31:2];
   assign w_midx   = addr_i[AW+1:2];
   assign w_in_dm  = (w_word < DM_LIM);
   assign w_in_out = (w_word >= OUT_W) && (w_word < OUT_W + 30'(NUM_OUT));
   assign w_in_in  = (w_word >= IN_W) && (w_word < IN_W + 30'(NUM_IN));

   always_comb begin
      w_f3_ok = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010,
         3'b100, 3'b101: w_f3_ok = 1'b1;
         default:        w_f3_ok = 1'b0;
      endcase
   end

   assign w_misal = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

   assign w_err = !w_f3_ok || w_misal ||
                  !(w_in_dm || w_in_out || w_in_in) ||
                  (we_i && w_in_in);

   // Reset masks the handshake so nothing is accepted or delivered under it.
   assign ready_o  = (r_state == S_IDLE) && !rst_i;
   assign rvalid_o = (r_state == S_RESP) && !rst_i;
   assign rdata_o  = r_rdata;

   assign w_acc = req_i && ready_o;
   assign w_st  = w_acc && we_i;
   assign w_ld  = w_acc && !we_i;
   assign w_wr  = w_st && !w_err;

   assign err_o = (w_st && w_err) || (rvalid_o && r_lerr);

   always_comb begin
      w_be    = 4'b1111;
      w_wlane = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wlane = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{wdata_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wlane = wdata_i;
         end
      endcase
   end

   always_comb begin
      w_rword = '0;
      if (w_in_dm) w_rword = r_mem[w_midx];
      for (int k = 0; k < NUM_OUT; k++)
         if (w_word == OUT_W + 30'(k)) w_rword = r_out[k];
      for (int k = 0; k < NUM_IN; k++)
         if (w_word == IN_W + 30'(k)) w_rword = r_sync2[32*k +: 32];
   end

   assign w_shift = w_rword >> {addr_i[1:0], 3'b000};

   always_comb begin
      w_lval = w_shift;
      case (funct3_i)
         3'b000:  w_lval = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_lval = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_lval = {24'h0, w_shift[7:0]};
         3'b101:  w_lval = {16'h0, w_shift[15:0]};
         default: w_lval = w_shift;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_rdata <= '0;
         r_lerr  <= 1'b0;
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= io_in_i;
         r_sync2 <= r_sync1;
         case (r_state)
            S_IDLE: begin
               if (w_ld) begin
                  r_state <= S_RESP;
                  r_rdata <= w_err ? 32'h0 : w_lval;
                  r_lerr  <= w_err;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr && w_in_dm) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_midx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
      end else if (w_wr && w_in_out) begin
         for (int k = 0; k < NUM_OUT; k++)
            for (int b = 0; b < 4; b++)
               if ((w_word == OUT_W + 30'(k)) && w_be[b])
                  r_out[k][8*b +: 8] <= w_wlane[8*b +: 8];
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign io_out_o[32*g +: 32] = r_out[g];
   end

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// tb_lsu_mmio_pipe: random + directed scoreboard bench for lsu_mmio_pipe.
// Byte-level reference model; a negedge monitor checks every DUT response.
module tb_lsu_mmio_pipe;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          we;
   logic [2:0]    f3;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          ready_o;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic [31:0]   io_in;
   logic [351:0]  io_out;

   always #5 clk = ~clk;

   lsu_mmio_pipe dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .we_i     (we),
      .funct3_i (f3),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .ready_o  (ready_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .io_in_i  (io_in),
      .io_out_o (io_out)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  m_ram [1024];
   logic [7:0]  m_out [44];
   logic [31:0] pin_prev;
   logic [31:0] pin_cur;
   int          pin_cyc;

   logic [32:0] lq [$];
   logic        sq [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int region(input logic [31:0] a);
      logic [31:0] w;
      w = a / 4;
      if (w < 256) return 1;
      if (w >= 32'h100 && w < 32'h10B) return 2;
      if (w == 32'h140) return 3;
      return 0;
   endfunction

   function automatic int size_of(input logic [2:0] f);
      case (f)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic model_err(input logic w, input logic [2:0] f, input logic [31:0] a);
      int sz;
      int r;
      sz = size_of(f);
      if (sz == 0) return 1'b1;
      if ((a % sz) != 0) return 1'b1;
      r = region(a);
      if (r == 0) return 1'b1;
      if (w && r == 3) return 1'b1;
      return 1'b0;
   endfunction

   // Synchronised pins reach a load accepted at least 3 edges after the change.
   function automatic logic [7:0] get_byte(input logic [31:0] a, input int acc_cyc);
      logic [31:0] pv;
      case (region(a))
         1: return m_ram[a];
         2: return m_out[a - 32'h400];
         3: begin
            pv = (acc_cyc >= pin_cyc + 3) ? pin_cur : pin_prev;
            return 8'(pv >> (8 * (a - 32'h500)));
         end
         default: return 8'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input int acc_cyc);
      logic [31:0] v;
      int sz;
      if (model_err(1'b0, f, a)) return 32'h0;
      sz = size_of(f);
      v = 32'h0;
      for (int i = 0; i < sz; i++)
         v = v | (32'(get_byte(a + i, acc_cyc)) << (8 * i));
      if (!f[2] && sz == 1 && v[7]) v = v | 32'hFFFF_FF00;
      if (!f[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      if (model_err(1'b1, f, a)) return;
      for (int i = 0; i < size_of(f); i++) begin
         if (region(a) == 1) m_ram[a + i] = 8'(d >> (8 * i));
         else m_out[a + i - 32'h400] = 8'(d >> (8 * i));
      end
   endtask

   task automatic set_pins(input logic [31:0] v);
      pin_prev = pin_cur;
      pin_cur  = v;
      pin_cyc  = cyc;
      io_in    = v;
   endtask

   task automatic model_reset();
      for (int j = 0; j < 44; j++) m_out[j] = 8'h0;
      pin_prev = 32'h0;
      pin_cur  = io_in;
      pin_cyc  = cyc;
   endtask

   // Called and returns at posedge+1; loads also wait out their RESP cycle.
   task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input bit push, input bit use_exp,
                        input logic [31:0] exp_d);
      bit acc;
      int n;
      logic e;
      logic [31:0] v;
      req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
      if (w) sq.push_back(model_err(1'b1, f, a));
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      req = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: addr %h not accepted in %0d cycles", a, n);
         if (w) void'(sq.pop_back());
         return;
      end
      chk("accept_cycles", 32'(n), 32'd1);
      if (w) begin
         model_store(f, a, d);
      end else if (push) begin
         e = model_err(1'b0, f, a);
         v = use_exp ? exp_d : model_load(f, a, cyc);
         lq.push_back({e, v});
         @(negedge clk);
         chk("load_latency_rvalid", 32'(rvalid_o), 32'd1);
         chk("resp_ready_low", 32'(ready_o), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_out();
      logic [351:0] ex;
      for (int j = 0; j < 44; j++) ex[8*j +: 8] = m_out[j];
      checks++;
      if (io_out !== ex) begin
         errors++;
         $display("FAIL io_out: got %h expected %h", io_out, ex);
      end
   endtask

   logic [32:0] mon_exp;
   logic        mon_se;

   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_in_reset: got %b expected 0", rvalid_o);
         end
      end else if (req && we && ready_o) begin
         checks++;
         if (sq.size() == 0) begin
            errors++;
            $display("FAIL store_sb_empty: store seen with no expectation");
         end else begin
            mon_se = sq.pop_front();
            if (err_o !== mon_se) begin
               errors++;
               $display("FAIL store_err: addr %h got %b expected %b", addr, err_o, mon_se);
            end
         end
      end else if (rvalid_o) begin
         checks++;
         if (lq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: rdata %h", rdata_o);
         end else begin
            mon_exp = lq.pop_front();
            if ({err_o, rdata_o} !== mon_exp) begin
               errors++;
               $display("FAIL load_resp: got err %b data %h expected err %b data %h",
                        err_o, rdata_o, mon_exp[32], mon_exp[31:0]);
            end
         end
      end else begin
         checks++;
         if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_err: err_o %b with no access", err_o);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   logic [2:0]  bad_f3 [3] = '{3'd3, 3'd6, 3'd7};

   initial begin
      logic [31:0] a;
      logic [2:0]  f;
      logic        w;
      int          r;
      rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0;
      addr = 32'h0; wdata = 32'h0; io_in = 32'h0;
      pin_prev = 32'h0; pin_cur = 32'h0; pin_cyc = 0;
      for (int j = 0; j < 44; j++) m_out[j] = 8'h0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("io_out_reset", 32'(io_out != '0), 32'd0);
      chk("ready_reset", 32'(ready_o), 32'd1);
      chk("rvalid_reset", 32'(rvalid_o), 32'd0);
      chk("err_reset", 32'(err_o), 32'd0);
      chk("rdata_reset", rdata_o, 32'h0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 256; i++)
         issue(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0);

      issue(1'b1, 3'd2, 32'h10, 32'h8899AABB, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 3'd0, 32'h11, 32'h0, 1'b1, 1'b1, 32'hFFFFFFAA);
      issue(1'b0, 3'd4, 32'h11, 32'h0, 1'b1, 1'b1, 32'h000000AA);
      issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 1'b1, 32'hFFFF8899);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b1, 32'h8899AABB);

      issue(1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
      chk("out0_sw", io_out[31:0], 32'hFFFFFFFF);
      issue(1'b1, 3'd0, 32'h401, 32'h12, 1'b0, 1'b0, 32'h0);
      chk("out0_sb", io_out[31:0], 32'hFFFF12FF);
      issue(1'b1, 3'd1, 32'h402, 32'h3456, 1'b0, 1'b0, 32'h0);
      chk("out0_sh", io_out[31:0], 32'h345612FF);

      issue(1'b0, 3'd1, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0);
      issue(1'b1, 3'd2, 32'h22, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
      issue(1'b1, 3'd2, 32'h2000, 32'h1, 1'b0, 1'b0, 32'h0);
      chk_out();

      set_pins(32'h0001ABCD);
      issue(1'b0, 3'd2, 32'h500, 32'h0, 1'b1, 1'b1, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      issue(1'b0, 3'd2, 32'h500, 32'h0, 1'b1, 1'b1, 32'h0001ABCD);
      issue(1'b1, 3'd2, 32'h500, 32'h55555555, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 3'd2, 32'h500, 32'h0, 1'b1, 1'b1, 32'h0001ABCD);

      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("rvalid_rst_in_resp", 32'(rvalid_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("ready_after_rst", 32'(ready_o), 32'd1);
      chk("rvalid_after_rst", 32'(rvalid_o), 32'd0);
      chk("io_out_after_rst", 32'(io_out != '0), 32'd0);
      @(posedge clk);
      #1;
      issue(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 3'd2, 32'h30, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) a = $urandom_range(0, 1023);
         else if (r <= 7) a = 32'h400 + $urandom_range(0, 47);
         else if (r == 8) a = 32'h500 + $urandom_range(0, 7);
         else a = $urandom;
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) f = bad_f3[$urandom_range(0, 2)];
         else if (w) f = 3'($urandom_range(0, 2));
         else f = ld_f3[$urandom_range(0, 4)];
         if ($urandom_range(0, 1) == 1 && size_of(f) != 0)
            a = a & ~(32'(size_of(f)) - 32'd1);
         if ($urandom_range(0, 7) == 0 && cyc >= pin_cyc + 3)
            set_pins($urandom);
         issue(w, f, a, $urandom, 1'b1, 1'b0, 32'h0);
         if (i % 16 == 15) chk_out();
      end

      repeat (3) @(posedge clk);
      #1;
      chk("load_queue_empty", 32'(lq.size()), 32'd0);
      chk("store_queue_empty", 32'(sq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
